// File: rtl/pipe_hazard_ctrl.sv
// Hazard scheduler for the F/X/M pipeline: forwarding selects, interlocks,
// cache-miss freezes, branch flush, mult/div occupancy and stall counters.
module pipe_hazard_ctrl #(
    parameter int MD_LAT = 32,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs_x,
    input  logic [4:0]       rt_x,
    input  logic             use_rs_x,
    input  logic             use_rt_x,
    input  logic             md_start_x,
    input  logic             mfhilo_x,
    input  logic             branch_x,
    input  logic [4:0]       wa_m,
    input  logic             regwe_m,
    input  logic             memrd_m,
    input  logic             icache_stall,
    input  logic             dcache_stall,
    output logic             stall_f,
    output logic             stall_x,
    output logic             stall_m,
    output logic             bubble_x,
    output logic             bubble_m,
    output logic             flush_f,
    output logic             fw_rs,
    output logic             fw_rt,
    output logic             md_busy,
    output logic [2:0]       cause,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] lduse_cnt
);

    typedef enum logic {MD_IDLE, MD_BUSY} mdState_t;

    localparam logic [5:0] MD_LOAD = 6'(MD_LAT - 1);

    localparam logic [2:0] CAUSE_NONE  = 3'd0;
    localparam logic [2:0] CAUSE_DMISS = 3'd1;
    localparam logic [2:0] CAUSE_IMISS = 3'd2;
    localparam logic [2:0] CAUSE_MD    = 3'd3;
    localparam logic [2:0] CAUSE_LDUSE = 3'd4;

    mdState_t         mdState, mdNext;
    logic [5:0]       mdCnt, mdCntNext;
    logic [CNT_W-1:0] stallCnt, lduseCnt;

    logic hitRs, hitRt, loadUse, mdHaz, mdBusyInt;
    logic stallF, stallX, stallM, bubbleX, bubbleM;
    logic [2:0] causeInt;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign mdBusyInt = (mdState == MD_BUSY);
    assign hitRs     = use_rs_x & regwe_m & (wa_m != 5'd0) & (rs_x == wa_m);
    assign hitRt     = use_rt_x & regwe_m & (wa_m != 5'd0) & (rt_x == wa_m);
    assign loadUse   = memrd_m & (hitRs | hitRt);
    assign mdHaz     = (mfhilo_x | md_start_x) & mdBusyInt;

    always_comb begin
        stallF   = 1'b0;
        stallX   = 1'b0;
        stallM   = 1'b0;
        bubbleX  = 1'b0;
        bubbleM  = 1'b0;
        causeInt = CAUSE_NONE;
        if (dcache_stall) begin
            stallF   = 1'b1;
            stallX   = 1'b1;
            stallM   = 1'b1;
            causeInt = CAUSE_DMISS;
        end else if (icache_stall) begin
            // F is refetching: X and M drain while a bubble enters X.
            stallF   = 1'b1;
            bubbleX  = 1'b1;
            causeInt = CAUSE_IMISS;
        end else if (mdHaz) begin
            stallF   = 1'b1;
            stallX   = 1'b1;
            bubbleM  = 1'b1;
            causeInt = CAUSE_MD;
        end else if (loadUse) begin
            stallF   = 1'b1;
            stallX   = 1'b1;
            bubbleM  = 1'b1;
            causeInt = CAUSE_LDUSE;
        end
    end

    // Occupancy counts down even through cache freezes, since the unit runs on its own.
    always_comb begin
        mdNext    = mdState;
        mdCntNext = mdCnt;
        case (mdState)
            MD_IDLE: begin
                if (md_start_x && !stallX) begin
                    mdNext    = MD_BUSY;
                    mdCntNext = MD_LOAD;
                end
            end
            MD_BUSY: begin
                if (mdCnt == 6'd0) mdNext = MD_IDLE;
                else               mdCntNext = mdCnt - 6'd1;
            end
            default: mdNext = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mdState <= MD_IDLE;
            mdCnt   <= 6'd0;
        end else begin
            mdState <= mdNext;
            mdCnt   <= mdCntNext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCnt <= '0;
            lduseCnt <= '0;
        end else begin
            if (stallX)                   stallCnt <= satInc(stallCnt);
            if (causeInt == CAUSE_LDUSE)  lduseCnt <= satInc(lduseCnt);
        end
    end

    // Every control output is forced low while reset is held.
    assign stall_f   = stallF  & ~rst;
    assign stall_x   = stallX  & ~rst;
    assign stall_m   = stallM  & ~rst;
    assign bubble_x  = bubbleX & ~rst;
    assign bubble_m  = bubbleM & ~rst;
    assign flush_f   = branch_x & ~stallX & ~rst;
    assign fw_rs     = hitRs & ~memrd_m & ~stallX & ~rst;
    assign fw_rt     = hitRt & ~memrd_m & ~stallX & ~rst;
    assign md_busy   = mdBusyInt & ~rst;
    assign cause     = rst ? CAUSE_NONE : causeInt;
    assign stall_cnt = stallCnt;
    assign lduse_cnt = lduseCnt;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Stall/flush/forward scheduler for the 3-stage MIPS pipeline: F (fetch/decode), X (execute), M (memory/writeback).
- Combines M->X forwarding selects, load-use interlock, I/D-cache miss freezes, mult/div busy interlock and taken-branch flush into one set of stage-enable controls.
- Keeps a cycle-exact mult/div occupancy FSM and saturating stall performance counters.
- Sits beside the datapath; drives the F/X/M pipeline-register enables and bubble muxes.

Parameters:
- MD_LAT, 32, mult/div latency in cycles from accepted issue to HI/LO valid (range 2..63).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rs_x  in  5  rs of instruction in X
- rt_x  in  5  rt of instruction in X
- use_rs_x  in  1  X instruction reads rs
- use_rt_x  in  1  X instruction reads rt
- md_start_x  in  1  X instruction is mult/multu/div/divu
- mfhilo_x  in  1  X instruction is mfhi/mflo
- branch_x  in  1  X instruction is a taken branch/jump
- wa_m  in  5  write address of instruction in M
- regwe_m  in  1  M instruction writes the register file
- memrd_m  in  1  M instruction is a load
- icache_stall  in  1  I-cache miss pending (level)
- dcache_stall  in  1  D-cache miss pending (level)
- stall_f  out  1  hold F register
- stall_x  out  1  hold X register
- stall_m  out  1  hold M register
- bubble_x  out  1  load NOP into X
- bubble_m  out  1  load NOP into M
- flush_f  out  1  kill instruction in F
- fw_rs  out  1  forward M result to X rs operand
- fw_rt  out  1  forward M result to X rt operand
- md_busy  out  1  mult/div unit occupied
- cause  out  3  stall cause: 0 none, 1 dmiss, 2 imiss, 3 md, 4 load-use
- stall_cnt  out  CNT_W  cycles with stall_x=1, saturating
- lduse_cnt  out  CNT_W  load-use interlocks taken, saturating

Behaviour:
- Reset (async, rst=1): md FSM=IDLE, md_cnt=0, both counters=0. All outputs combinationally 0 while rst=1.
- Hazard terms (combinational):
  - hit_rs = use_rs_x & regwe_m & wa_m!=0 & rs_x==wa_m; hit_rt likewise for rt.
  - lduse = memrd_m & (hit_rs | hit_rt).
  - mdh = (mfhilo_x | md_start_x) & md_busy.
- Priority, one cause per cycle, highest first:
  1. dcache_stall: stall_f=stall_x=stall_m=1, no bubbles, cause=1.
  2. icache_stall: bubble_x=1, stall_f=1, cause=2; X/M advance.
  3. mdh: stall_f=stall_x=1, bubble_m=1, cause=3.
  4. lduse: stall_f=stall_x=1, bubble_m=1, cause=4.
  5. Otherwise all stall/bubble outputs 0, cause=0.
- Load-use is exactly one cycle: next cycle M holds the bubble, so lduse cannot re-fire. No extra state.
- Forwarding:
  - fw_rs = hit_rs & ~memrd_m & ~stall_x; fw_rt likewise.
  - Suppressed during any freeze, because M data is not consumed.
- flush_f = branch_x & ~stall_x. A branch held in X flushes only in the cycle it advances.
- Mult/div FSM:
  - IDLE -> BUSY when md_start_x & ~stall_x & ~rst; load md_cnt=MD_LAT-1.
  - BUSY: md_cnt decrements every cycle, including dcache/icache freezes. At md_cnt==0, BUSY -> IDLE next edge.
  - md_busy = (state==BUSY).
  - Issue while BUSY is held by mdh until IDLE, then accepted in that IDLE cycle.
  - Simultaneous dcache_stall and a new md_start_x: start not accepted (stall_x=1).
- Counters, on rising clk:
  - stall_cnt += 1 when stall_x=1.
  - lduse_cnt += 1 when cause==4.
  - Both saturate at all-ones; no wrap.
- Reset mid-operation (BUSY or during a miss) returns to IDLE immediately; a pending mult/div is discarded.

Test Plan:
- ALU forward: M writes r5 (regwe_m=1, memrd_m=0, wa_m=5), X reads rs_x=5 -> fw_rs=1, fw_rt=0, no stall, cause=0. Repeat with wa_m=0 -> fw_rs=0.
- Load-use: memrd_m=1, wa_m=7, rt_x=7, use_rt_x=1 -> one cycle of stall_f=stall_x=bubble_m=1, cause=4, fw_rt=0, lduse_cnt 0->1. Following cycle no stall.
- Mult/div interlock, MD_LAT=4: issue mult at cycle 0 -> md_busy=1 for cycles 1-4. mfhi in X at cycle 2 -> stall_x=1 for cycles 2-4, released at cycle 5, stall_cnt=3.
- Priority: dcache_stall=1 with lduse=1 and branch_x=1 for 3 cycles -> cause=1, stall_m=1, bubble_m=0, flush_f=0. On release, cause=4 for one cycle, then flush_f=1.
- I-miss: icache_stall=1 for 2 cycles, X holds an ALU op -> bubble_x=1, stall_f=1, stall_x=0 both cycles, stall_cnt unchanged.
- Async reset: assert rst mid-BUSY (md_cnt=10) between clock edges -> md_busy, all stalls, and counters go to 0 immediately. After release, a new mult is accepted on the first cycle.
